// File: rtl/rio_tx_arbiter_if.sv
// Source-side and link-side signals of the RIO tx arbiter, bundled for port hookup.
// master = arbiter side, slave = sources/link side.
interface rio_tx_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_SRC    = 4,
  parameter int PTR_W      = 2
);
  logic [NUM_SRC-1:0]            i_src_req;
  logic [NUM_SRC-1:0]            i_src_valid;
  logic [NUM_SRC-1:0]            i_src_sop;
  logic [NUM_SRC-1:0]            i_src_eop;
  logic [NUM_SRC*DATA_WIDTH-1:0] i_src_data;
  logic [NUM_SRC-1:0]            o_src_rdy;
  logic                          o_tx_valid;
  logic                          o_tx_sop;
  logic                          o_tx_eop;
  logic [DATA_WIDTH-1:0]         o_tx_data;
  logic                          i_tx_rdy;
  logic [PTR_W-1:0]              o_grant_id;
  logic                          o_busy;
  logic                          o_err;

  modport master (
    input  i_src_req, i_src_valid, i_src_sop, i_src_eop, i_src_data, i_tx_rdy,
    output o_src_rdy, o_tx_valid, o_tx_sop, o_tx_eop, o_tx_data,
           o_grant_id, o_busy, o_err
  );

  modport slave (
    output i_src_req, i_src_valid, i_src_sop, i_src_eop, i_src_data, i_tx_rdy,
    input  o_src_rdy, o_tx_valid, o_tx_sop, o_tx_eop, o_tx_data,
           o_grant_id, o_busy, o_err
  );
endinterface

// File: rtl/rio_tx_arbiter.sv
// Packet-atomic round-robin arbiter: grants one source, then forwards its whole
// SOP..EOP burst onto the tx link through a single output register stage.
module rio_tx_arbiter #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_SRC     = 4,
  parameter int PTR_W       = 2,
  parameter int SOP_TIMEOUT = 15
) (
  input logic              clk,
  input logic              rst,
  rio_tx_arbiter_if.master bus
);

  localparam logic [4:0] ARB_IDLE  = 5'b00001;
  localparam logic [4:0] ARB_GRANT = 5'b00010;
  localparam logic [4:0] ARB_WAIT  = 5'b00100;
  localparam logic [4:0] ARB_PASS  = 5'b01000;
  localparam logic [4:0] ARB_GAP   = 5'b10000;

  logic [4:0]            state_q, state_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [PTR_W-1:0]      grant_q, grant_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  tx_sop_q, tx_sop_d;
  logic                  tx_eop_q, tx_eop_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  err_q, err_d;

  logic [NUM_SRC-1:0]    gnt_mask;
  logic                  w_valid, w_sop, w_eop;
  logic [DATA_WIDTH-1:0] w_data;
  logic [PTR_W-1:0]      winner;
  logic [PTR_W-1:0]      cand;
  logic                  win_found;
  logic                  fwd;
  logic                  in_window;
  logic                  foreign;

  assign gnt_mask = NUM_SRC'(1) << grant_q;
  assign w_valid  = bus.i_src_valid[grant_q];
  assign w_sop    = bus.i_src_sop[grant_q];
  assign w_eop    = bus.i_src_eop[grant_q];

  always_comb begin
    w_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q == PTR_W'(i)) w_data = bus.i_src_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Round-robin scan starting just after the last granted source.
  always_comb begin
    winner    = ptr_q;
    win_found = 1'b0;
    cand      = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      cand = PTR_W'((int'(ptr_q) + i) % NUM_SRC);
      if (!win_found && bus.i_src_req[cand]) begin
        winner    = cand;
        win_found = 1'b1;
      end
    end
  end

  assign in_window = (state_q == ARB_WAIT) || (state_q == ARB_PASS);
  assign foreign   = |(bus.i_src_valid & (in_window ? ~gnt_mask : {NUM_SRC{1'b1}}));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    fwd     = 1'b0;
    err_d   = foreign;
    case (state_q)
      ARB_IDLE: begin
        if (bus.i_tx_rdy && win_found) begin
          grant_d = winner;
          ptr_d   = winner;
          state_d = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        cnt_d   = 8'(SOP_TIMEOUT);
        state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (w_valid && w_sop) begin
          fwd     = 1'b1;
          state_d = w_eop ? ARB_GAP : ARB_PASS;
        end else if (cnt_q == 8'd0) begin
          err_d   = 1'b1;
          state_d = ARB_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ARB_PASS: begin
        if (w_valid) begin
          fwd = 1'b1;
          if (w_sop) err_d = 1'b1;
          if (w_eop) state_d = ARB_GAP;
        end
      end
      ARB_GAP:  state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  assign tx_valid_d = fwd;
  assign tx_sop_d   = fwd & w_sop;
  assign tx_eop_d   = fwd & w_eop;
  assign tx_data_d  = fwd ? w_data : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      ptr_q      <= PTR_W'(NUM_SRC - 1);
      grant_q    <= '0;
      cnt_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_sop_q   <= 1'b0;
      tx_eop_q   <= 1'b0;
      tx_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      cnt_q      <= cnt_d;
      tx_valid_q <= tx_valid_d;
      tx_sop_q   <= tx_sop_d;
      tx_eop_q   <= tx_eop_d;
      tx_data_q  <= tx_data_d;
      err_q      <= err_d;
    end
  end

  assign bus.o_src_rdy  = (state_q == ARB_GRANT) ? gnt_mask : '0;
  assign bus.o_tx_valid = tx_valid_q;
  assign bus.o_tx_sop   = tx_sop_q;
  assign bus.o_tx_eop   = tx_eop_q;
  assign bus.o_tx_data  = tx_data_q;
  assign bus.o_grant_id = grant_q;
  assign bus.o_busy     = (state_q != ARB_IDLE);
  assign bus.o_err      = err_q;

endmodule

// File: tb/tb_rio_tx_arbiter.sv
// Directed + randomized bench for rio_tx_arbiter; sources are modelled as packet
// generators and the link is checked word by word against what they sent.
module tb_rio_tx_arbiter;
  localparam int DW = 16;
  localparam int NS = 4;
  localparam int PW = 2;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   last_ptr;

  rio_tx_arbiter_if #(.DATA_WIDTH(DW), .NUM_SRC(NS), .PTR_W(PW)) bus();

  rio_tx_arbiter #(
    .DATA_WIDTH(DW), .NUM_SRC(NS), .PTR_W(PW), .SOP_TIMEOUT(TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Round-robin reference: first requester after the last granted index.
  function automatic int next_winner(input logic [NS-1:0] req);
    for (int k = 1; k <= NS; k++) begin
      int c = (last_ptr + k) % NS;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  task automatic clear_src();
    bus.i_src_valid = '0;
    bus.i_src_sop   = '0;
    bus.i_src_eop   = '0;
    bus.i_src_data  = '0;
  endtask

  task automatic drive_word(input int src, input logic [DW-1:0] d, input bit sop, input bit eop);
    clear_src();
    bus.i_src_valid[src]           = 1'b1;
    bus.i_src_sop[src]             = sop;
    bus.i_src_eop[src]             = eop;
    bus.i_src_data[src*DW +: DW]   = d;
  endtask

  task automatic wait_grant(input int exp_src);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.o_src_rdy == '0 && n < 40);
    check("grant_seen", {31'b0, bus.o_src_rdy != '0}, 32'd1);
    check("grant_onehot", {28'b0, bus.o_src_rdy}, 32'd1 << exp_src);
    check("grant_id", {30'b0, bus.o_grant_id}, 32'(exp_src));
    check("grant_busy", {31'b0, bus.o_busy}, 32'd1);
    last_ptr = exp_src;
  endtask

  // mode 0: clean packet; 1: foreign source valid at word 'at'; 2: repeated SOP at word 'at'
  task automatic send_pkt(input int src, input int len, input bit seq_data,
                          input int mode, input int at);
    logic [DW-1:0] d;
    int dly = $urandom_range(0, 2);
    int f   = (src + 1) % NS;
    bit bad;
    @(negedge clk);
    check("wait_link_idle", {31'b0, bus.o_tx_valid}, 32'd0);
    repeat (dly) begin
      @(negedge clk);
      check("wait_link_idle", {31'b0, bus.o_tx_valid}, 32'd0);
    end
    for (int w = 0; w < len; w++) begin
      if (w > 0 && $urandom_range(0, 3) == 0) begin
        clear_src();
        @(negedge clk);
        check("bubble_valid", {31'b0, bus.o_tx_valid}, 32'd0);
        check("bubble_err", {31'b0, bus.o_err}, 32'd0);
      end
      d = seq_data ? DW'(w) : DW'($urandom);
      drive_word(src, d, w == 0, w == len - 1);
      bad = (mode != 0) && (w == at);
      if (mode == 1 && w == at) begin
        bus.i_src_valid[f]         = 1'b1;
        bus.i_src_sop[f]           = 1'b1;
        bus.i_src_data[f*DW +: DW] = ~d;
      end
      if (mode == 2 && w == at) bus.i_src_sop[src] = 1'b1;
      @(negedge clk);
      check("tx_valid", {31'b0, bus.o_tx_valid}, 32'd1);
      check("tx_sop", {31'b0, bus.o_tx_sop}, {31'b0, (w == 0) || (mode == 2 && w == at)});
      check("tx_eop", {31'b0, bus.o_tx_eop}, {31'b0, w == len - 1});
      check("tx_data", {16'b0, bus.o_tx_data}, {16'b0, d});
      check("tx_err", {31'b0, bus.o_err}, {31'b0, bad});
    end
    clear_src();
    @(negedge clk);
    check("gap_valid", {31'b0, bus.o_tx_valid}, 32'd0);
    check("gap_idle", {31'b0, bus.o_busy}, 32'd0);
  endtask

  initial begin
    int exp;
    int n;
    rst            = 1'b1;
    bus.i_tx_rdy   = 1'b0;
    bus.i_src_req  = '0;
    clear_src();
    last_ptr       = NS - 1;
    repeat (3) @(negedge clk);
    check("rst_rdy", {28'b0, bus.o_src_rdy}, 32'd0);
    check("rst_valid", {31'b0, bus.o_tx_valid}, 32'd0);
    check("rst_sop", {31'b0, bus.o_tx_sop}, 32'd0);
    check("rst_eop", {31'b0, bus.o_tx_eop}, 32'd0);
    check("rst_data", {16'b0, bus.o_tx_data}, 32'd0);
    check("rst_gid", {30'b0, bus.o_grant_id}, 32'd0);
    check("rst_busy", {31'b0, bus.o_busy}, 32'd0);
    check("rst_err", {31'b0, bus.o_err}, 32'd0);
    rst = 1'b0;

    // link not ready: requests must wait
    bus.i_src_req = 4'b0101;
    repeat (4) begin
      @(negedge clk);
      check("txrdy_low_idle", {31'b0, bus.o_busy}, 32'd0);
    end
    bus.i_tx_rdy = 1'b1;

    // first packet from reset goes to src 0, data 0,1,2
    exp = next_winner(bus.i_src_req);
    check("first_winner_model", 32'(exp), 32'd0);
    wait_grant(exp);
    send_pkt(exp, 3, 1'b1, 0, 0);

    // all sources requesting: strict rotation
    bus.i_src_req = '1;
    repeat (5) begin
      exp = next_winner(bus.i_src_req);
      wait_grant(exp);
      send_pkt(exp, $urandom_range(1, 5), 1'b0, 0, 0);
    end

    // random request patterns
    repeat (12) begin
      bus.i_src_req = NS'($urandom_range(1, (1 << NS) - 1));
      exp = next_winner(bus.i_src_req);
      wait_grant(exp);
      send_pkt(exp, $urandom_range(1, 6), 1'b0, 0, 0);
    end

    // single-word packet
    bus.i_src_req = '1;
    exp = next_winner(bus.i_src_req);
    wait_grant(exp);
    send_pkt(exp, 1, 1'b0, 0, 0);

    // foreign source talking out of turn
    exp = next_winner(bus.i_src_req);
    wait_grant(exp);
    send_pkt(exp, 4, 1'b0, 1, 1);

    // second SOP inside a packet
    exp = next_winner(bus.i_src_req);
    wait_grant(exp);
    send_pkt(exp, 3, 1'b0, 2, 1);

    // granted source never sends SOP
    exp = next_winner(bus.i_src_req);
    wait_grant(exp);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.o_err && n < 300);
    check("timeout_cycles", 32'(n), 32'(TO + 2));
    check("timeout_idle", {31'b0, bus.o_busy}, 32'd0);
    check("timeout_link", {31'b0, bus.o_tx_valid}, 32'd0);
    exp = next_winner(bus.i_src_req);
    wait_grant(exp);
    send_pkt(exp, 2, 1'b0, 0, 0);

    // reset in the middle of a packet
    exp = next_winner(bus.i_src_req);
    wait_grant(exp);
    @(negedge clk);
    drive_word(exp, 16'h1234, 1'b1, 1'b0);
    @(negedge clk);
    drive_word(exp, 16'h5678, 1'b0, 1'b0);
    @(negedge clk);
    check("pre_rst_data", {16'b0, bus.o_tx_data}, 32'h5678);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'b0, bus.o_tx_valid}, 32'd0);
    check("mid_rst_eop", {31'b0, bus.o_tx_eop}, 32'd0);
    check("mid_rst_data", {16'b0, bus.o_tx_data}, 32'd0);
    check("mid_rst_gid", {30'b0, bus.o_grant_id}, 32'd0);
    check("mid_rst_busy", {31'b0, bus.o_busy}, 32'd0);
    clear_src();
    @(negedge clk);
    rst      = 1'b0;
    last_ptr = NS - 1;
    exp = next_winner(bus.i_src_req);
    wait_grant(exp);
    send_pkt(exp, 3, 1'b0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
